// File: rtl/tri_bus_arbiter_if.sv
// ============================================================================
// Module  : tri_bus_arbiter_if
// Brief   : Request/grant/bus bundle between requesters and tri_bus_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface tri_bus_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int c_ow = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        last;
  logic [NREQ-1:0][W-1:0] wdata;
  logic [NREQ-1:0]        gnt;
  logic [c_ow-1:0]        owner;
  logic                   bus_oe;
  logic [W-1:0]           bus_data;
  logic                   timeout;
  logic                   busy;

  // Requester side
  modport master (
    output req, last, wdata,
    input  gnt, owner, bus_oe, bus_data, timeout, busy
  );

  // Arbiter side
  modport slave (
    input  req, last, wdata,
    output gnt, owner, bus_oe, bus_data, timeout, busy
  );
endinterface

`default_nettype wire

// File: rtl/tri_bus_arbiter.sv
// ============================================================================
// Module  : tri_bus_arbiter
// Brief   : Round-robin single-owner bus arbiter with one-cycle turnaround
//           and a hold timeout that revokes long ownerships.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tri_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  tri_bus_arbiter_if.slave  bus
);

  localparam int              c_ow       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0]      c_idle     = 2'd0;
  localparam logic [1:0]      c_grant    = 2'd1;
  localparam logic [1:0]      c_turn     = 2'd2;
  localparam logic [7:0]      c_max_hold = 8'(MAX_HOLD);
  localparam logic [c_ow-1:0] c_last_idx = c_ow'(NREQ - 1);
  localparam logic [c_ow:0]   c_nreq     = (c_ow + 1)'(NREQ);
  localparam logic [NREQ-1:0] c_one      = NREQ'(1);

  logic [1:0]      r_state;
  logic [c_ow-1:0] r_ptr;
  logic [c_ow-1:0] r_owner;
  logic [7:0]      r_hold;
  logic [NREQ-1:0] r_gnt;
  logic            r_bus_oe;
  logic            r_timeout;

  logic [1:0]      w_state_nxt;
  logic [c_ow-1:0] w_ptr_nxt;
  logic [c_ow-1:0] w_owner_nxt;
  logic [7:0]      w_hold_nxt;
  logic [NREQ-1:0] w_gnt_nxt;
  logic            w_timeout_nxt;

  logic            w_any_req;
  logic            w_found;
  logic [c_ow:0]   w_sum;
  logic [c_ow-1:0] w_idx;
  logic [c_ow-1:0] w_pick;
  logic            w_own_req;
  logic            w_own_last;
  logic            w_expire;
  logic            w_release;
  logic [W-1:0]    w_bus_data;

  assign w_any_req  = |bus.req;
  assign w_own_req  = bus.req[r_owner];
  assign w_own_last = bus.last[r_owner];
  assign w_expire   = (r_hold == c_max_hold);
  assign w_release  = !w_own_req || w_own_last || w_expire;

  // Rotating priority: first set request at or above r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, r_ptr} + (c_ow + 1)'(i);
      if (w_sum >= c_nreq) begin
        w_sum = w_sum - c_nreq;
      end
      w_idx = w_sum[c_ow-1:0];
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_idle;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_hold    <= '0;
      r_gnt     <= '0;
      r_bus_oe  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_hold    <= w_hold_nxt;
      r_gnt     <= w_gnt_nxt;
      r_bus_oe  <= |w_gnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  w_state_nxt = w_any_req ? c_grant : c_idle;
      c_grant: w_state_nxt = w_release ? c_turn : c_grant;
      c_turn:  w_state_nxt = w_any_req ? c_grant : c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    w_gnt_nxt     = '0;
    w_owner_nxt   = r_owner;
    w_hold_nxt    = r_hold;
    w_ptr_nxt     = r_ptr;
    w_timeout_nxt = 1'b0;
    case (r_state)
      c_idle, c_turn: begin
        if (w_any_req) begin
          w_owner_nxt = w_pick;
          w_gnt_nxt   = c_one << w_pick;
          w_hold_nxt  = 8'd1;
        end else begin
          w_hold_nxt  = '0;
        end
      end
      c_grant: begin
        if (w_release) begin
          w_ptr_nxt     = (r_owner == c_last_idx) ? '0 : r_owner + 1'b1;
          w_hold_nxt    = '0;
          // Timeout only when the hold limit alone caused the release.
          w_timeout_nxt = w_own_req && !w_own_last;
        end else begin
          w_gnt_nxt     = r_gnt;
          w_hold_nxt    = r_hold + 8'd1;
        end
      end
      default: begin
        w_hold_nxt = '0;
      end
    endcase
  end

  assign w_bus_data   = r_bus_oe ? bus.wdata[r_owner] : '0;

  assign bus.gnt      = r_gnt;
  assign bus.owner    = r_owner;
  assign bus.bus_oe   = r_bus_oe;
  assign bus.bus_data = w_bus_data;
  assign bus.timeout  = r_timeout;
  assign bus.busy     = (r_state != c_idle);

endmodule

`default_nettype wire

// File: tb/tb_tri_bus_arbiter.sv
// ============================================================================
// Module  : tb_tri_bus_arbiter
// Brief   : Directed self-checking bench for tri_bus_arbiter (NREQ=4, W=8).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tri_bus_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  tri_bus_arbiter_if #(.NREQ(4), .W(8)) bif ();

  tri_bus_arbiter #(.NREQ(4), .W(8), .MAX_HOLD(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};
    total = 0;
    bad   = 0;
    rst_n     = 1'b0;
    bif.req   = '0;
    bif.last  = '0;
    bif.wdata = '0;

    // Reset state
    #3;
    chk("rst_outputs", {bif.gnt, bif.owner, bif.bus_oe, bif.bus_data, bif.timeout, bif.busy}, 0);
    tick();
    rst_n = 1'b1;

    // Idle with no requests
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_quiet", {bif.gnt, bif.bus_oe, bif.busy, bif.bus_data}, 0);
    end

    // Single requester 2, last on its third grant cycle
    bif.wdata[2] = 8'hA5;
    bif.req      = 4'b0100;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk("single_gnt", bif.gnt, 4'b0100);
      chk("single_data", bif.bus_data, 8'hA5);
      chk("single_oe", bif.bus_oe, 1'b1);
    end
    bif.last = 4'b0100;
    tick();
    chk("single_turn", {bif.gnt, bif.bus_oe, bif.bus_data, bif.busy}, 1);
    bif.req  = '0;
    bif.last = '0;
    tick();
    chk("single_idle_busy", bif.busy, 1'b0);
    chk("single_owner", bif.owner, 2);

    // Round robin across all four, one-cycle grants
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) bif.wdata[k] = 8'h10 + 8'(k);
    bif.req  = 4'b1111;
    bif.last = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_gnt", bif.gnt, 32'd1 << order[k]);
      chk("rr_data", bif.bus_data, 8'h10 + 8'(order[k]));
      chk("rr_onehot_oe", {28'd0, bif.bus_oe, 3'($countones(bif.gnt))}, {28'd0, 1'b1, 3'd1});
      if (k == 4) begin
        bif.req  = '0;
        bif.last = '0;
      end
      tick();
      chk("rr_turn", {bif.gnt, bif.bus_oe, bif.bus_data}, 0);
    end
    tick();
    chk("rr_idle", bif.busy, 1'b0);

    // Hold timeout on requester 1
    bif.req = 4'b0010;
    tick();
    for (int c = 1; c <= 15; c++) begin
      chk("hold_gnt", bif.gnt, 4'b0010);
      chk("hold_no_timeout", bif.timeout, 1'b0);
      if (c < 15) tick();
    end
    tick();
    chk("hold_turn_gnt", bif.gnt, 4'b0000);
    chk("hold_timeout", bif.timeout, 1'b1);
    tick();
    chk("hold_regrant", bif.gnt, 4'b0010);
    chk("hold_timeout_clear", bif.timeout, 1'b0);

    // last coincident with hold expiry on cycle 15
    for (int c = 2; c <= 15; c++) begin
      tick();
      chk("coinc_gnt", bif.gnt, 4'b0010);
    end
    bif.last = 4'b0010;
    tick();
    chk("coinc_turn_gnt", bif.gnt, 4'b0000);
    chk("coinc_timeout", bif.timeout, 1'b0);

    // req drop in grant cycle 2
    bif.last = '0;
    tick();
    chk("drop_gnt1", bif.gnt, 4'b0010);
    tick();
    chk("drop_gnt2", bif.gnt, 4'b0010);
    bif.req = '0;
    tick();
    chk("drop_turn", {bif.gnt, bif.timeout, bif.busy}, 1);
    tick();
    chk("drop_idle", bif.busy, 1'b0);

    // Asynchronous reset during owner 3's grant
    bif.wdata[3] = 8'h3C;
    bif.req      = 4'b1000;
    tick();
    chk("pre_rst_gnt", bif.gnt, 4'b1000);
    chk("pre_rst_data", bif.bus_data, 8'h3C);
    chk("pre_rst_owner", bif.owner, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {bif.gnt, bif.bus_oe, bif.bus_data, bif.owner, bif.busy, bif.timeout}, 0);
    bif.req = 4'b1001;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_gnt", bif.gnt, 4'b0001);
    chk("post_rst_owner", bif.owner, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
